// File: rtl/arbitro_rr_param.sv
// Round-robin switch from NUM_CH show-ahead input FIFOs to NUM_CH output FIFOs,
// routed by the destination field in each word. Define ARB_BURST_EN for burst grants.
module arbitro_rr_param #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           empty_in,
    input  logic [NUM_CH*DATA_W-1:0]    data_in,
    output logic [NUM_CH-1:0]           pop_in,
    input  logic [NUM_CH-1:0]           almost_full_out,
    output logic [NUM_CH-1:0]           push_out,
    output logic [DATA_W-1:0]           data_out,
    output logic [$clog2(NUM_CH)-1:0]   grant_ch,
    output logic                        idle
);

    localparam int unsigned DEST_W = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
        $error("arbitro_rr_param: NUM_CH must be 2..8");
    end
    if (BURST_MAX < 1) begin : g_bad_burst_max
        $error("arbitro_rr_param: BURST_MAX must be at least 1");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DEST_W-1:0]   r_ptr;
    logic [DEST_W-1:0]   w_ptr_nxt;
    logic [DEST_W-1:0]   r_grant_ch;
    logic [DEST_W-1:0]   w_g;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_word;
    logic [NUM_CH-1:0]   w_elig;
    logic [NUM_CH-1:0]   w_blocked;
    logic                w_pop;

`ifdef ARB_BURST_EN
    localparam int unsigned BCW = $clog2(BURST_MAX + 1);
    logic [BCW-1:0]      r_cnt;
    logic [BCW-1:0]      w_cnt_nxt;
    logic [BCW-1:0]      w_cnt_inc;
`endif

    // Exact modulo-NUM_CH add; both operands are below NUM_CH so one subtract suffices.
    function automatic logic [DEST_W-1:0] wrap_add(input logic [DEST_W-1:0] a, input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        if (s >= NUM_CH) s = s - NUM_CH;
        return DEST_W'(s);
    endfunction

    // State register; r_state==S_GRANT doubles as the in-flight word valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_data     <= '0;
            r_grant_ch <= '0;
`ifdef ARB_BURST_EN
            r_cnt      <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
`ifdef ARB_BURST_EN
            r_cnt   <= w_cnt_nxt;
`endif
            if (w_pop) begin
                r_data     <= w_word;
                r_grant_ch <= w_g;
            end
        end
    end

    // Eligibility, rotating search from r_ptr, pointer update and output decode.
    always_comb begin
        w_elig      = '0;
        w_blocked   = '0;
        w_g         = r_ptr;
        w_pop       = 1'b0;
        pop_in      = '0;
        push_out    = '0;
        w_ptr_nxt   = r_ptr;
        w_state_nxt = S_IDLE;
`ifdef ARB_BURST_EN
        w_cnt_nxt   = r_cnt;
        w_cnt_inc   = '0;
`endif

        for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned d = 0; d < NUM_CH; d++) begin
                if (data_in[c*DATA_W + DATA_W - DEST_W +: DEST_W] == DEST_W'(d))
                    w_blocked[c] = almost_full_out[d];
            end
            w_elig[c] = !empty_in[c] && !w_blocked[c];
        end

        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!w_pop && w_elig[wrap_add(r_ptr, k)]) begin
                w_g   = wrap_add(r_ptr, k);
                w_pop = 1'b1;
            end
        end
        if (reset) w_pop = 1'b0;

        w_word      = data_in[32'(w_g)*DATA_W +: DATA_W];
        w_state_nxt = w_pop ? S_GRANT : S_IDLE;

`ifdef ARB_BURST_EN
        // The pointer parks on the bursting channel so the search re-finds it first.
        if (w_pop) begin
            w_cnt_inc = (w_g == r_ptr) ? BCW'(r_cnt + 1'b1) : BCW'(1);
            if (w_cnt_inc == BCW'(BURST_MAX)) begin
                w_ptr_nxt = wrap_add(w_g, 1);
                w_cnt_nxt = '0;
            end else begin
                w_ptr_nxt = w_g;
                w_cnt_nxt = w_cnt_inc;
            end
        end else if (r_cnt != '0) begin
            w_ptr_nxt = wrap_add(r_ptr, 1);
            w_cnt_nxt = '0;
        end
`else
        if (w_pop) w_ptr_nxt = wrap_add(w_g, 1);
`endif

        for (int unsigned c = 0; c < NUM_CH; c++) begin
            pop_in[c]   = w_pop && (w_g == DEST_W'(c));
            push_out[c] = (r_state == S_GRANT) && (r_data[DATA_W-1 -: DEST_W] == DEST_W'(c));
        end

        idle     = !w_pop;
        grant_ch = w_pop ? w_g : r_grant_ch;
        data_out = r_data;
    end

endmodule

// File: tb/tb_arbitro_rr_param.sv
// Scoreboard bench for arbitro_rr_param: a 4-channel instance fed by queue FIFO models
// and a 3-channel instance with all channels permanently eligible.
module tb_arbitro_rr_param;

    logic        clk;
    logic        reset;
    logic [3:0]  empty_in;
    logic [39:0] data_in;
    logic [3:0]  pop_in;
    logic [3:0]  almost_full_out;
    logic [3:0]  push_out;
    logic [9:0]  data_out;
    logic [1:0]  grant_ch;
    logic        idle;

    logic        reset3;
    logic [2:0]  pop3;
    logic [2:0]  push3;
    logic [9:0]  dout3;
    logic [1:0]  g3;
    logic        idle3;

    typedef struct {
        int         g;
        logic [9:0] w;
    } exp_t;

    exp_t       exp_q[$];
    int         exp3_q[$];
    logic [9:0] fq[4][$];
    logic [3:0] af;
    logic [3:0] pend_pop;
    logic       push_due;
    logic [3:0] exp_pmask;
    logic [9:0] exp_pdata;
    logic       push3_due;
    logic [2:0] exp3_pmask;
    logic [9:0] exp3_pdata;
    logic [2:0] pm3[3] = '{3'b100, 3'b001, 3'b010};
    logic [9:0] dw3[3] = '{10'h2C0, 10'h0C1, 10'h1C2};
    int         n_chk;
    int         n_bad;

    arbitro_rr_param #(.NUM_CH(4), .DATA_W(10), .BURST_MAX(4)) dut4 (
        .clk(clk), .reset(reset), .empty_in(empty_in), .data_in(data_in),
        .pop_in(pop_in), .almost_full_out(almost_full_out), .push_out(push_out),
        .data_out(data_out), .grant_ch(grant_ch), .idle(idle)
    );

    arbitro_rr_param #(.NUM_CH(3), .DATA_W(10), .BURST_MAX(1)) dut3 (
        .clk(clk), .reset(reset3), .empty_in(3'b000), .data_in({10'h1C2, 10'h0C1, 10'h2C0}),
        .pop_in(pop3), .almost_full_out(3'b000), .push_out(push3),
        .data_out(dout3), .grant_ch(g3), .idle(idle3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    // Scoreboard monitor for the 4-channel instance.
    always @(negedge clk) begin
        exp_t e;
        pend_pop = pop_in;
        if (push_due) begin
            chk("push_out", 32'(push_out), 32'(exp_pmask));
            chk("data_out", 32'(data_out), 32'(exp_pdata));
            push_due = 1'b0;
        end else if (push_out !== 4'b0) begin
            chk("unexpected_push", 32'(push_out), 32'h0);
        end
        if (pop_in !== 4'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 32'(pop_in), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("pop_in", 32'(pop_in), 32'(4'(1) << e.g));
                chk("grant_ch", 32'(grant_ch), 32'(e.g));
                exp_pmask = 4'(1) << e.w[9:8];
                exp_pdata = e.w;
                push_due  = 1'b1;
            end
        end
    end

    // Scoreboard monitor for the 3-channel instance.
    always @(negedge clk) begin
        int e3;
        if (push3_due) begin
            chk("push3", 32'(push3), 32'(exp3_pmask));
            chk("data3", 32'(dout3), 32'(exp3_pdata));
            push3_due = 1'b0;
        end
        if (!reset3 && exp3_q.size() != 0) begin
            e3 = exp3_q.pop_front();
            chk("pop3", 32'(pop3), 32'(3'(1) << e3));
            chk("grant3", 32'({idle3, g3}), 32'(e3));
            chk("ptr3_lt3", 32'(dut3.r_ptr < 2'd3), 32'd1);
            exp3_pmask = pm3[e3];
            exp3_pdata = dw3[e3];
            push3_due  = 1'b1;
        end
    end

    task automatic drive();
        for (int c = 0; c < 4; c++) begin
            empty_in[c]        = (fq[c].size() == 0);
            data_in[c*10 +: 10] = (fq[c].size() != 0) ? fq[c][0] : 10'h0;
        end
        almost_full_out = af;
    endtask

    task automatic load(input int c, input logic [9:0] w);
        fq[c].push_back(w);
        drive();
    endtask

    task automatic expect_grant(input int g, input logic [9:0] w);
        exp_t e;
        e.g = g;
        e.w = w;
        exp_q.push_back(e);
    endtask

    // One clock: retire the heads popped in the cycle just ended, then re-drive.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++)
            if (pend_pop[c] && fq[c].size() != 0) fq[c].delete(0);
        drive();
    endtask

    task automatic run_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || push_due) && n < 60) begin
            cycle();
            n++;
        end
        if (n >= 60) begin
            chk({name, "_timeout"}, 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
    endtask

    initial begin
        n_chk = 0; n_bad = 0;
        push_due = 1'b0; push3_due = 1'b0;
        af = 4'b0; pend_pop = 4'b0;
        reset = 1'b1; reset3 = 1'b1;
        drive();

        // Reset with all channels loaded.
`ifdef ARB_BURST_EN
        load(0, 10'h0A0); load(0, 10'h1A1); load(0, 10'h2A2);
        load(0, 10'h3A3); load(0, 10'h0A4); load(0, 10'h1A5);
        load(1, 10'h2B0); load(1, 10'h3B1);
`else
        load(0, 10'h110); load(0, 10'h314);
        load(1, 10'h211); load(2, 10'h012); load(3, 10'h313);
`endif
        cycle();
        @(negedge clk);
        chk("rst_pop_in", 32'(pop_in), 32'h0);
        chk("rst_push_out", 32'(push_out), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);
        chk("rst_grant_ch", 32'(grant_ch), 32'h0);
        chk("rst_data_out", 32'(data_out), 32'h0);
        cycle();
        reset = 1'b0;
`ifdef ARB_BURST_EN
        expect_grant(0, 10'h0A0); expect_grant(0, 10'h1A1);
        expect_grant(0, 10'h2A2); expect_grant(0, 10'h3A3);
        expect_grant(1, 10'h2B0); expect_grant(1, 10'h3B1);
        expect_grant(0, 10'h0A4); expect_grant(0, 10'h1A5);
        run_drain("burst");
`else
        expect_grant(0, 10'h110); expect_grant(1, 10'h211);
        expect_grant(2, 10'h012); expect_grant(3, 10'h313);
        expect_grant(0, 10'h314);
        run_drain("fair");
`endif
        cycle();

        // Destination 2 blocked: ch1 waits, ch3 goes first.
        af = 4'b0100;
        load(1, 10'h221); load(3, 10'h023);
        expect_grant(3, 10'h023);
        run_drain("stall");
        repeat (2) begin
            cycle();
            @(negedge clk);
            chk("stall_idle", 32'(idle), 32'h1);
            chk("stall_grant_hold", 32'(grant_ch), 32'h3);
        end
        cycle();
        af = 4'b0000;
        drive();
        expect_grant(1, 10'h221);
        run_drain("unstall");
        cycle();

        // Single eligible channel is granted every cycle.
        load(0, 10'h030); load(0, 10'h131); load(0, 10'h232);
        expect_grant(0, 10'h030); expect_grant(0, 10'h131); expect_grant(0, 10'h232);
        run_drain("single");
        cycle();

        // Reset in the cycle after a pop discards everything after it.
        load(1, 10'h341); load(2, 10'h142);
        expect_grant(1, 10'h341);
        cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_pop_in", 32'(pop_in), 32'h0);
        cycle();
        reset = 1'b0;
        expect_grant(2, 10'h142);
        @(negedge clk);
        chk("midrst_no_push", 32'(push_out), 32'h0);
        chk("midrst_data_out", 32'(data_out), 32'h0);
        run_drain("midrst");

        // Three channels: exact wrap of the pointer.
        exp3_q = '{0, 1, 2, 0, 1};
        cycle();
        reset3 = 1'b0;
        begin
            int n;
            n = 0;
            while ((exp3_q.size() != 0 || push3_due) && n < 30) begin
                cycle();
                if (exp3_q.size() == 0) reset3 = 1'b1;
                n++;
            end
            if (n >= 30) chk("wrap3_timeout", 32'(exp3_q.size()), 32'h0);
        end
        reset3 = 1'b1;
        cycle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/arbitro_rr_param.md
ARBITRO_RR_PARAM -- requirements
Module: arbitro_rr_param

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of input FIFOs and output FIFOs, range 2..8.
REQ-002 SHALL have parameter DATA_W, default 10: word width; DEST_W = clog2(NUM_CH), and the destination field is data[DATA_W-1 -: DEST_W].
REQ-003 SHALL have parameter BURST_MAX, default 4: maximum consecutive grants per channel; used only with ARB_BURST_EN.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port empty_in, input, NUM_CH bits: empty flag of each input FIFO.
REQ-007 SHALL have port data_in, input, NUM_CH*DATA_W bits: head word of each show-ahead input FIFO; channel c occupies slice [c*DATA_W +: DATA_W].
REQ-008 SHALL have port pop_in, output, NUM_CH bits: one-hot or zero pop strobe to the input FIFOs.
REQ-009 SHALL have port almost_full_out, input, NUM_CH bits: almost-full flag of each output FIFO.
REQ-010 SHALL have port push_out, output, NUM_CH bits: one-hot or zero push strobe to the output FIFOs.
REQ-011 SHALL have port data_out, output, DATA_W bits: word broadcast to all output FIFOs; qualified by push_out.
REQ-012 SHALL have port grant_ch, output, DEST_W bits: index of the channel popped in the current cycle; holds its last value when idle.
REQ-013 SHALL have port idle, output, 1 bit: high when no pop occurs in the current cycle.

Function
REQ-014 Channel c SHALL be eligible when empty_in[c]=0 and almost_full_out[dest(head c)]=0; a blocked destination stalls only the channels whose head word targets it.
REQ-015 Arbitration SHALL be combinational from registered state: search order is rr_ptr, rr_ptr+1, ... modulo NUM_CH, and the first eligible channel is granted; the modulo SHALL be exact for NUM_CH values that are not a power of two.
REQ-016 pop_in[g] SHALL assert in the same cycle as grant g; at most one pop_in bit SHALL be high per cycle.
REQ-017 On a pop, the popped word SHALL be registered; in the next cycle push_out[dest] SHALL be 1 and data_out SHALL equal the word; pop-to-push latency is exactly 1 cycle.
REQ-018 Back-to-back pops SHALL give push_out every cycle, i.e. full throughput.
REQ-019 The block SHALL act on almost_full_out as sampled in the pop cycle and SHALL NOT cancel a word already in flight; output FIFOs SHALL set the almost-full threshold to leave room for 1 in-flight word.
REQ-020 FSM states SHALL be IDLE (no eligible channel; pop_in=0, idle=1) and GRANT (one pop this cycle).
REQ-021 IDLE->GRANT and GRANT->GRANT SHALL occur when any channel is eligible, and GRANT->IDLE when none is.
REQ-022 After a grant to g without bursting, rr_ptr SHALL become (g+1) mod NUM_CH; in IDLE, rr_ptr SHALL hold.
REQ-023 When only one channel is eligible, that channel SHALL be granted every cycle.
REQ-024 In cycles with no pop, push_out SHALL be 0 in the following cycle and data_out SHALL hold its last value.

Reset
REQ-025 While reset=1 at a rising edge, the following SHALL be set: rr_ptr=0, state=IDLE, burst_cnt=0, in-flight valid=0, push_out=0, data_out=0, grant_ch=0.
REQ-026 While reset=1, pop_in SHALL be 0 and idle SHALL be 1, overriding eligibility.
REQ-027 A reset asserted mid-operation SHALL discard the in-flight word, so no push occurs in the cycle after reset; the first pop SHALL be possible in the first cycle with reset=0.

Configuration
REQ-028 With macro ARB_BURST_EN defined, the granted channel SHALL keep the grant while eligible, up to BURST_MAX consecutive pops, counted by burst_cnt with width clog2(BURST_MAX+1).
REQ-029 With ARB_BURST_EN defined, rr_ptr SHALL advance to (g+1) mod NUM_CH when burst_cnt reaches BURST_MAX or when g becomes ineligible, and burst_cnt SHALL then clear.
REQ-030 Without ARB_BURST_EN, the burst logic SHALL be absent, the BURST_MAX parameter SHALL be ignored, and plain round-robin (REQ-022) SHALL apply.

Verification
REQ-031 Reset test: with all 4 channels non-empty, apply reset for 2 cycles -> pop_in=0 and push_out=0 during reset; the first grant after release is ch0.
REQ-032 Fairness test: NUM_CH=4, all non-empty, destinations not blocked, no burst -> grants are 0,1,2,3,0; each word appears on data_out 1 cycle after its pop with the correct push_out bit.
REQ-033 Per-destination stall test: set almost_full_out[2]=1, head ch1 dest=2, head ch3 dest=0 -> ch1 is skipped and ch3 is granted; ch1 is granted once almost_full_out[2]=0.
REQ-034 Wrap/non-power-of-2 test: NUM_CH=3 with all channels eligible -> grant sequence 0,1,2,0,1; rr_ptr never reaches 3.
REQ-035 Burst test: ARB_BURST_EN defined, BURST_MAX=4, ch0 holds 6 words and ch1 holds 2 -> grants 0,0,0,0,1,1,0,0.
REQ-036 Mid-operation reset test: assert reset in the cycle after a pop -> no push in the following cycle; data_out=0 after reset.
